// File: rtl/key_event_ctrl.sv
// key_event_ctrl
//   Turns N debounced key levels into press / release / auto-repeat events.
//   Each key has a hold FSM and a one-deep pending slot. A round-robin
//   arbiter moves one slot per cycle into a shared show-ahead event FIFO.
// Ports
//   clk, rst_n     : key clock, asynchronous active-low reset
//   key_debounced  : debounced key levels, 1 = pressed
//   evt_ready      : consumer accepts the head entry
//   evt_valid      : FIFO not empty
//   evt_key        : key index of the head entry
//   evt_type       : 00 press, 01 release, 10 repeat
//   overflow       : sticky, set when a press/release is lost
//   overflow_clr   : synchronous clear of overflow (a same-cycle set wins)
module key_event_ctrl #(
  parameter int N_KEYS        = 4,
  parameter int HOLD_CYCLES   = 100,
  parameter int REPEAT_CYCLES = 20,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_KEYS-1:0]         key_debounced,
  input  logic                      evt_ready,
  output logic                      evt_valid,
  output logic [$clog2(N_KEYS)-1:0] evt_key,
  output logic [1:0]                evt_type,
  output logic                      overflow,
  input  logic                      overflow_clr
);

  localparam int          KW   = $clog2(N_KEYS);
  localparam int          MAXC = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int          CW   = $clog2(MAXC);
  localparam int          AW   = $clog2(FIFO_DEPTH);
  localparam int unsigned NK   = N_KEYS;

  localparam logic [CW-1:0] HOLD_TC  = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] RPT_TC   = CW'(REPEAT_CYCLES - 1);
  localparam logic [AW:0]   DEPTH_L  = (AW+1)'(FIFO_DEPTH);
  localparam logic [KW-1:0] LAST_KEY = KW'(N_KEYS - 1);

  typedef enum logic [1:0] {
    EV_PRESS   = 2'b00,
    EV_RELEASE = 2'b01,
    EV_REPEAT  = 2'b10
  } ev_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HELD,
    S_RPT
  } state_e;

  // key sampling
  logic [N_KEYS-1:0] k_q;
  logic [N_KEYS-1:0] rise, fall;

  // per-key FSM and slot
  state_e            state_q [N_KEYS];
  state_e            state_d [N_KEYS];
  logic [CW-1:0]     cnt_q   [N_KEYS];
  logic [CW-1:0]     cnt_d   [N_KEYS];
  logic [N_KEYS-1:0] gen_v;
  ev_e               gen_t   [N_KEYS];
  logic [N_KEYS-1:0] slot_v_q, slot_v_d;
  ev_e               slot_t_q [N_KEYS];
  ev_e               slot_t_d [N_KEYS];
  logic              set_ovf;

  // arbiter
  logic [KW-1:0]     rr_q, rr_d;
  logic              grant_v;
  logic [KW-1:0]     grant_idx;
  int unsigned       idx;

  // FIFO
  logic [KW+1:0]     mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_q, rd_q;
  logic [AW:0]       fcnt_q;
  logic              push, pop;
  logic              ovf_q;

  assign rise = key_debounced & ~k_q;
  assign fall = ~key_debounced & k_q;

  // Hold FSM: fall beats the terminal count because it is tested first.
  always_comb begin
    for (int unsigned i = 0; i < NK; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      gen_v[i]   = 1'b0;
      gen_t[i]   = EV_PRESS;
      case (state_q[i])
        S_IDLE: begin
          if (rise[i]) begin
            gen_v[i]   = 1'b1;
            gen_t[i]   = EV_PRESS;
            state_d[i] = S_HELD;
            cnt_d[i]   = '0;
          end
        end
        S_HELD, S_RPT: begin
          if (fall[i]) begin
            gen_v[i]   = 1'b1;
            gen_t[i]   = EV_RELEASE;
            state_d[i] = S_IDLE;
          end else if (cnt_q[i] == ((state_q[i] == S_HELD) ? HOLD_TC : RPT_TC)) begin
            gen_v[i]   = 1'b1;
            gen_t[i]   = EV_REPEAT;
            state_d[i] = S_RPT;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i]   = cnt_q[i] + 1'b1;
          end
        end
        default: state_d[i] = S_IDLE;
      endcase
    end
  end

  // Round-robin grant, only while the registered count shows space.
  always_comb begin
    grant_v   = 1'b0;
    grant_idx = '0;
    idx       = 0;
    if (fcnt_q < DEPTH_L) begin
      for (int unsigned j = 0; j < NK; j++) begin
        idx = 32'(rr_q) + j;
        if (idx >= NK) idx = idx - NK;
        if (!grant_v && slot_v_q[KW'(idx)]) begin
          grant_v   = 1'b1;
          grant_idx = KW'(idx);
        end
      end
    end
    rr_d = rr_q;
    if (grant_v) rr_d = (grant_idx == LAST_KEY) ? '0 : grant_idx + 1'b1;
  end

  // Slot update: a slot being granted this cycle is treated as free.
  always_comb begin
    set_ovf = 1'b0;
    for (int unsigned i = 0; i < NK; i++) begin
      slot_v_d[i] = slot_v_q[i];
      slot_t_d[i] = slot_t_q[i];
      if (gen_v[i]) begin
        if (slot_v_q[i] && !(grant_v && (grant_idx == KW'(i)))) begin
          if (gen_t[i] != EV_REPEAT) begin
            slot_t_d[i] = gen_t[i];
            set_ovf     = 1'b1;
          end
        end else begin
          slot_v_d[i] = 1'b1;
          slot_t_d[i] = gen_t[i];
        end
      end else if (grant_v && (grant_idx == KW'(i))) begin
        slot_v_d[i] = 1'b0;
      end
    end
  end

  assign push      = grant_v;
  assign evt_valid = (fcnt_q != '0);
  assign pop       = evt_valid & evt_ready;
  assign evt_key   = mem_q[rd_q][KW+1:2];
  assign evt_type  = mem_q[rd_q][1:0];
  assign overflow  = ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q      <= '0;
      slot_v_q <= '0;
      rr_q     <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
      fcnt_q   <= '0;
      ovf_q    <= 1'b0;
      for (int unsigned i = 0; i < NK; i++) begin
        state_q[i]  <= S_IDLE;
        cnt_q[i]    <= '0;
        slot_t_q[i] <= EV_PRESS;
      end
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      k_q      <= key_debounced;
      slot_v_q <= slot_v_d;
      rr_q     <= rr_d;
      ovf_q    <= set_ovf ? 1'b1 : (overflow_clr ? 1'b0 : ovf_q);
      for (int unsigned i = 0; i < NK; i++) begin
        state_q[i]  <= state_d[i];
        cnt_q[i]    <= cnt_d[i];
        slot_t_q[i] <= slot_t_d[i];
      end
      if (push) begin
        mem_q[wr_q] <= {grant_idx, slot_t_q[grant_idx]};
        wr_q        <= wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
      case ({push, pop})
        2'b10:   fcnt_q <= fcnt_q + 1'b1;
        2'b01:   fcnt_q <= fcnt_q - 1'b1;
        default: fcnt_q <= fcnt_q;
      endcase
    end
  end

endmodule

// File: tb/tb_key_event_ctrl.sv
// Self-checking bench for key_event_ctrl: a fixed vector table for a single
// press/release, hand-written corner sequences, and a randomized run, all
// compared every cycle against a behavioural event model.
module tb_key_event_ctrl;

  localparam int NK   = 4;
  localparam int HOLD = 100;
  localparam int RPT  = 20;
  localparam int DEP  = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] key;
  logic       ready;
  logic       clr;
  logic       valid;
  logic [1:0] ekey;
  logic [1:0] etype;
  logic       ovf;

  key_event_ctrl #(
    .N_KEYS(NK), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(RPT), .FIFO_DEPTH(DEP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_debounced(key), .evt_ready(ready),
    .evt_valid(valid), .evt_key(ekey), .evt_type(etype),
    .overflow(ovf), .overflow_clr(clr)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // behavioural model: age = edges since press (-1 when not held)
  int m_age [NK];
  bit m_kprev [NK];
  bit m_pv [NK];
  int m_pt [NK];
  int m_ptr;
  int m_fifo [$];
  bit m_ovf;

  typedef struct { int cyc; int k; int t; } pop_t;
  pop_t log_q [$];

  typedef struct {
    logic [3:0] key; logic ready; logic clr;
    logic exp_valid; logic [1:0] exp_key; logic [1:0] exp_type; logic exp_ovf;
  } vec_t;
  vec_t tbl [8];

  task automatic check(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NK; i++) begin
      m_age[i] = -1; m_kprev[i] = 0; m_pv[i] = 0; m_pt[i] = 0;
    end
    m_ptr = 0;
    m_fifo.delete();
    m_ovf = 0;
  endtask

  task automatic model_edge(input logic [3:0] kv, input logic rdy, input logic cl);
    bit pop_e;
    int g;
    int ev;
    bit set;
    pop_e = (m_fifo.size() > 0) && rdy;
    g = -1;
    set = 0;
    if (m_fifo.size() < DEP)
      for (int j = 0; j < NK; j++)
        if (g < 0 && m_pv[(m_ptr + j) % NK]) g = (m_ptr + j) % NK;
    if (pop_e) void'(m_fifo.pop_front());
    if (g >= 0) m_fifo.push_back(g * 4 + m_pt[g]);
    for (int i = 0; i < NK; i++) begin
      ev = -1;
      if (m_age[i] < 0) begin
        if (kv[i] && !m_kprev[i]) begin ev = 0; m_age[i] = 0; end
      end else if (!kv[i] && m_kprev[i]) begin
        ev = 1; m_age[i] = -1;
      end else begin
        m_age[i]++;
        if (m_age[i] == HOLD || (m_age[i] > HOLD && (m_age[i] - HOLD) % RPT == 0)) ev = 2;
      end
      if (ev >= 0) begin
        if (m_pv[i] && g != i) begin
          if (ev != 2) begin m_pt[i] = ev; set = 1; end
        end else begin
          m_pv[i] = 1; m_pt[i] = ev;
        end
      end else if (g == i) begin
        m_pv[i] = 0;
      end
      m_kprev[i] = kv[i];
    end
    if (g >= 0) m_ptr = (g + 1) % NK;
    m_ovf = set ? 1'b1 : (cl ? 1'b0 : m_ovf);
  endtask

  task automatic check_model();
    bit bad;
    bad = 0;
    vectors++;
    if (valid !== (m_fifo.size() != 0)) begin
      bad = 1;
      $display("FAIL evt_valid: got %b expected %0d (cycle %0d)", valid, m_fifo.size() != 0, cyc);
    end else if (m_fifo.size() != 0 && (ekey !== 2'(m_fifo[0] / 4) || etype !== 2'(m_fifo[0] % 4))) begin
      bad = 1;
      $display("FAIL evt_head: got key %0d type %0d expected key %0d type %0d (cycle %0d)",
               ekey, etype, m_fifo[0] / 4, m_fifo[0] % 4, cyc);
    end
    if (ovf !== m_ovf) begin
      bad = 1;
      $display("FAIL overflow: got %b expected %0d (cycle %0d)", ovf, m_ovf, cyc);
    end
    if (bad) miscompares++;
  endtask

  // called at a negedge; applies inputs for the next rising edge
  task automatic step(input logic [3:0] kv, input logic rdy, input logic cl);
    key = kv; ready = rdy; clr = cl;
    if (valid && rdy) log_q.push_back('{cyc, int'(ekey), int'(etype)});
    model_edge(kv, rdy, cl);
    @(negedge clk);
    cyc++;
    check_model();
  endtask

  task automatic steps(input int n, input logic [3:0] kv, input logic rdy);
    for (int i = 0; i < n; i++) step(kv, rdy, 1'b0);
  endtask

  task automatic do_reset(input logic [3:0] kv);
    key = kv; ready = 1'b0; clr = 1'b0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_model();
  endtask

  task automatic chk_log(input string nm, input int i, input int k, input int t);
    if (i < log_q.size()) begin
      check({nm, "_key"}, log_q[i].k, k);
      check({nm, "_type"}, log_q[i].t, t);
    end else begin
      check({nm, "_len"}, log_q.size(), i + 1);
    end
  endtask

  initial begin
    logic [3:0] kr;
    logic       rr;
    int         t0;

    tbl[0] = '{4'b0100, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0};
    tbl[1] = '{4'b0100, 1'b1, 1'b0, 1'b1, 2'd2, 2'd0, 1'b0};
    tbl[2] = '{4'b0100, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0};
    tbl[3] = '{4'b0100, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0};
    tbl[4] = '{4'b0100, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0};
    tbl[5] = '{4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0};
    tbl[6] = '{4'b0000, 1'b1, 1'b0, 1'b1, 2'd2, 2'd1, 1'b0};
    tbl[7] = '{4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0};

    rst_n = 1'b0; key = '0; ready = 1'b0; clr = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_valid", int'(valid), 0);
    check("reset_key", int'(ekey), 0);
    check("reset_type", int'(etype), 0);
    check("reset_ovf", int'(ovf), 0);
    rst_n = 1'b1;

    // single press/release on key 2
    for (int i = 0; i < 8; i++) begin
      step(tbl[i].key, tbl[i].ready, tbl[i].clr);
      check($sformatf("tbl%0d_valid", i), int'(valid), int'(tbl[i].exp_valid));
      if (tbl[i].exp_valid) begin
        check($sformatf("tbl%0d_key", i), int'(ekey), int'(tbl[i].exp_key));
        check($sformatf("tbl%0d_type", i), int'(etype), int'(tbl[i].exp_type));
      end
      check($sformatf("tbl%0d_ovf", i), int'(ovf), int'(tbl[i].exp_ovf));
    end

    // hold / repeat on key 0
    log_q.delete();
    steps(150, 4'b0001, 1'b1);
    steps(4, 4'b0000, 1'b1);
    check("hold_count", log_q.size(), 5);
    chk_log("hold_press", 0, 0, 0);
    chk_log("hold_rep1", 1, 0, 2);
    chk_log("hold_rep2", 2, 0, 2);
    chk_log("hold_rep3", 3, 0, 2);
    chk_log("hold_rel", 4, 0, 1);
    if (log_q.size() == 5) begin
      t0 = log_q[0].cyc;
      check("hold_rep1_delay", log_q[1].cyc - t0, 100);
      check("hold_rep2_delay", log_q[2].cyc - t0, 120);
      check("hold_rep3_delay", log_q[3].cyc - t0, 140);
      check("hold_rel_delay", log_q[4].cyc - t0, 150);
    end

    // round robin from pointer 0
    do_reset(4'b0000);
    log_q.delete();
    steps(6, 4'b1110, 1'b1);
    steps(6, 4'b0000, 1'b1);
    steps(6, 4'b1001, 1'b1);
    steps(6, 4'b0000, 1'b1);
    check("rr_count", log_q.size(), 10);
    chk_log("rr0", 0, 1, 0); chk_log("rr1", 1, 2, 0); chk_log("rr2", 2, 3, 0);
    chk_log("rr3", 3, 1, 1); chk_log("rr4", 4, 2, 1); chk_log("rr5", 5, 3, 1);
    chk_log("rr6", 6, 0, 0); chk_log("rr7", 7, 3, 0);
    chk_log("rr8", 8, 0, 1); chk_log("rr9", 9, 3, 1);
    if (log_q.size() >= 3) begin
      check("rr_consec1", log_q[1].cyc - log_q[0].cyc, 1);
      check("rr_consec2", log_q[2].cyc - log_q[1].cyc, 1);
    end

    // FIFO full / backpressure / overflow
    do_reset(4'b0000);
    log_q.delete();
    steps(6, 4'b1111, 1'b0);
    steps(3, 4'b0000, 1'b0);
    check("full_ovf_before", int'(ovf), 0);
    check("full_valid", int'(valid), 1);
    step(4'b0001, 1'b0, 1'b0);
    check("full_ovf_after_key0", int'(ovf), 1);
    steps(2, 4'b1111, 1'b0);
    steps(2, 4'b0000, 1'b0);
    steps(14, 4'b0000, 1'b1);
    check("full_drained", int'(valid), 0);
    chk_log("full_p0", 0, 0, 0); chk_log("full_p1", 1, 1, 0);
    chk_log("full_p2", 2, 2, 0); chk_log("full_p3", 3, 3, 0);
    check("full_ovf_sticky", int'(ovf), 1);
    step(4'b0000, 1'b1, 1'b1);
    check("full_ovf_clr", int'(ovf), 0);

    // repeat coalescing with a full FIFO
    do_reset(4'b0000);
    log_q.delete();
    steps(6, 4'b1101, 1'b0);
    steps(3, 4'b1100, 1'b0);
    steps(300, 4'b1110, 1'b0);
    check("coal_ovf", int'(ovf), 0);
    steps(10, 4'b1110, 1'b1);
    chk_log("coal_k1", 4, 1, 0);
    chk_log("coal_k2", 5, 2, 2);
    chk_log("coal_k3", 6, 3, 2);
    steps(10, 4'b0000, 1'b1);

    // reset in the middle of operation
    do_reset(4'b0000);
    steps(3, 4'b0010, 1'b0);
    steps(3, 4'b0000, 1'b0);
    steps(3, 4'b0100, 1'b0);
    check("midrst_valid_before", int'(valid), 1);
    #2 rst_n = 1'b0;
    model_reset();
    #1 check("midrst_valid_async", int'(valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    check_model();
    log_q.delete();
    steps(8, 4'b0100, 1'b1);
    check("midrst_count", log_q.size(), 1);
    chk_log("midrst_press", 0, 2, 0);
    steps(4, 4'b0000, 1'b1);

    // randomized run
    kr = '0;
    rr = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 11) == 0) kr[$urandom_range(0, 3)] = ~kr[$urandom_range(0, 3) & 0 | kr[0] & 0];
      if ($urandom_range(0, 15) == 0) kr = kr ^ 4'($urandom_range(0, 15));
      if ($urandom_range(0, 29) == 0) rr = ~rr;
      step(kr, rr & ($urandom_range(0, 3) != 0), $urandom_range(0, 40) == 0);
    end
    steps(20, 4'b0000, 1'b1);
    check("final_empty", int'(valid), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
